seq_det_sched: RTL

Stream scheduler and controller for the team's serial 1011 overlapping sequence detector (seq_det).
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first onto the detector's serial input, one bit per clock.
- Owns the detector's reset, counts detector hits over a frame, and flags input underruns.
- Sits between a word-oriented producer and the bit-serial detector datapath.

---
 rtl/seq_det_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_det_sched.sv
// Word-to-bit scheduler for the serial 1011 detector: serialises handshaked words MSB-first,
// owns the detector reset, counts hits per frame and flags mid-frame underruns.
module seq_det_sched #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              seq_out,
   output logic              det_rst,
   input  logic              det_in,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              underrun
);
   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, STALL, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] shreg_p0;
   logic [BC_W-1:0]   bitcnt;
   logic              last_q;
   logic              vld_p1;
   logic              hs;
   logic              final_bit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign hs        = in_valid & in_ready;
   assign final_bit = (bitcnt == '0);
   // Shifting zeros in keeps the register clear outside SHIFT, so its MSB is the registered serial bit.
   assign seq_out   = shreg_p0[WORD_W-1];

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      det_rst   = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy    = 1'b0;
            det_rst = 1'b1;
            if (start) state_nxt = CLR;
         end
         CLR: begin
            det_rst   = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (final_bit) begin
               in_ready = ~last_q;
               if (last_q)        state_nxt = DRAIN;
               else if (in_valid) state_nxt = SHIFT;
               else               state_nxt = STALL;
            end
         end
         STALL: begin
            det_rst  = 1'b1;
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            det_rst   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shreg_p0  <= '0;
         bitcnt    <= '0;
         last_q    <= 1'b0;
         vld_p1    <= 1'b0;
         match_cnt <= '0;
         underrun  <= 1'b0;
      end else begin
         state  <= state_nxt;
         // p0 -> p1: det_in answers for the bit shown one cycle earlier
         vld_p1 <= (state == SHIFT);
         if (hs) begin
            shreg_p0 <= in_data;
            last_q   <= in_last;
            bitcnt   <= BC_W'(WORD_W - 1);
         end else if (state == SHIFT) begin
            shreg_p0 <= shreg_p0 << 1;
            bitcnt   <= bitcnt - BC_W'(1);
         end
         if ((state == IDLE && start) || state == CLR) begin
            match_cnt <= '0;
            underrun  <= 1'b0;
         end else begin
            if (vld_p1 && det_in) match_cnt <= sat_inc(match_cnt);
            if (state == SHIFT && state_nxt == STALL) underrun <= 1'b1;
         end
      end
   end
endmodule
